// File: rtl/mux_nx1_pkg.sv
// Shared constants for the N:1 registered channel selector.
// Holds the selection-mode codes and the output-stage state encoding.
package mux_nx1_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ost_e;

endpackage

// File: rtl/mux_nx1_reg_rr_arbiter.sv
// Combinational rotate-priority arbiter: grants the first requester after ptr,
// wrapping modulo N, so the last winner gets lowest priority next time.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          gnt_vld,
    output logic [SW-1:0] gnt_idx
);

    logic [SW-1:0] idx;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 1; k <= N; k++) begin
            idx = SW'((int'(ptr) + k) % N);
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/mux_nx1_reg.sv
// N:1 channel selector (fixed or round-robin) with a one-deep registered output.
// Optional registered parity output out_par is enabled by defining MUX_NX1_PARITY_EN.
module mux_nx1_reg
    import mux_nx1_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset_L,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic           en,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  out_ch
`ifdef MUX_NX1_PARITY_EN
   ,output logic           out_par
`endif
);

    ost_e          st_q, st_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          rr_vld;
    logic [SW-1:0] rr_idx;
    logic          fix_vld;
    logic          gnt_vld;
    logic [SW-1:0] gnt_idx;
    logic          space;
    logic          xfer;
    logic [W-1:0]  sel_data;

    rr_arbiter #(.N(N)) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt_vld (rr_vld),
        .gnt_idx (rr_idx)
    );

    // Compare against each legal index so an out-of-range sel never indexes in_valid.
    always_comb begin
        fix_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SW'(i) && in_valid[i]) fix_vld = 1'b1;
        end
    end

    always_comb begin
        gnt_vld  = (mode == MODE_RR) ? rr_vld : fix_vld;
        gnt_idx  = (mode == MODE_RR) ? rr_idx : sel;
        space    = (st_q == ST_EMPTY) || out_ready;
        xfer     = reset_L && en && space && gnt_vld;
        in_ready = '0;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == SW'(i)) begin
                in_ready[i] = xfer;
                sel_data    = in_data[i*W +: W];
            end
        end
    end

    // A transfer overrides the drain, giving back-to-back words with no bubble.
    always_comb begin
        st_d       = st_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        ptr_d      = ptr_q;
        if (xfer) begin
            st_d       = ST_FULL;
            out_data_d = sel_data;
            out_ch_d   = gnt_idx;
            if (mode == MODE_RR) ptr_d = gnt_idx;
        end else if (st_q == ST_FULL && out_ready) begin
            st_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            st_q       <= ST_EMPTY;
            out_data_q <= '0;
            out_ch_q   <= '0;
            ptr_q      <= SW'(N-1);
        end else begin
            st_q       <= st_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            ptr_q      <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = (st_q == ST_FULL);

`ifdef MUX_NX1_PARITY_EN
    logic out_par_q, out_par_d;

    assign out_par_d = ^out_data_d;

    always_ff @(posedge clk) begin
        if (!reset_L) out_par_q <= 1'b0;
        else          out_par_q <= out_par_d;
    end

    assign out_par = out_par_q;
`endif

endmodule
